// File: rtl/memory_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_stage_pkg
//  Description : Shared definitions for the MEM stage: access-size encodings,
//                write-back control bit positions, the MEM/WB register layout
//                and small helpers for byte enables, alignment and load
//                extension.
//  Revision    : 1.0  initial release
// ============================================================================
package memory_access_stage_pkg;

    // Access size encodings carried on inMemSize (2'b10 behaves as a word)
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

    // Bit positions inside the 2-bit write-back control field
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Contents of the MEM/WB pipeline register.  The load tags (load, size,
    // uns, off) travel with the access so lane selection and extension can
    // happen after the RAM output register.
    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        mis;
        logic        load;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
    } memwb_t;

    // A half must sit on an even byte, a word on a multiple of four.
    function automatic logic misaligned_access(input logic [1:0] size,
                                               input logic [1:0] off);
        logic result;
        case (size)
            MEM_BYTE: result = 1'b0;
            MEM_HALF: result = off[0];
            default:  result = (off != 2'b00);
        endcase
        return result;
    endfunction

    // Little-endian lane enables: offset 0 is bits [7:0].
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << off;
            MEM_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; replicate it so whichever lane is
    // enabled already sees the right bits.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            MEM_BYTE: lanes = {4{data[7:0]}};
            MEM_HALF: lanes = {2{data[15:0]}};
            default:  lanes = data;
        endcase
        return lanes;
    endfunction

    // Pick the addressed lane(s) out of the raw RAM word and extend.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_BYTE: result = uns ? {24'd0, b} : {{24{b[7]}}, b};
            MEM_HALF: result = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default:  result = word;
        endcase
        return result;
    endfunction

endpackage : memory_access_stage_pkg
`default_nettype wire

// File: rtl/memory_access_stage_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Dual-port synchronous RAM of 2**ADDR_WIDTH 32-bit words.
//                Port A: read/write with per-byte write enables, read-first,
//                        gated by a_en (output register holds when low).
//                Port B: read-only, registered every cycle.
//  Ports       : clk, rst        - clock, async active-high reset (output regs)
//                a_en            - port A enable (clock enable for the port)
//                a_we, a_be      - write strobe and byte enables
//                a_addr, a_wdata - word address and write data
//                a_rdata         - registered read data (old data on write)
//                b_addr, b_rdata - read-only port address / registered data
//  Revision    : 1.0  initial release
// ============================================================================
module data_memory #(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [3:0]            a_be,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [31:0]           a_wdata,
    output logic [31:0]           a_rdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [31:0]           b_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    // Array write: no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (a_be[lane]) begin
                    mem[a_addr][lane*8 +: 8] <= a_wdata[lane*8 +: 8];
                end
            end
        end
    end

    // Port A output register: sampled in the same edge as the write, so a
    // read of the word being written returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= 32'd0;
        end else if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    // Port B runs freely regardless of port A enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rdata <= 32'd0;
        end else begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule : data_memory
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_stage
//  Description : MEM stage of the 5-stage pipeline. Performs data-memory
//                loads and stores, holds the MEM/WB pipeline register and
//                extends load data for write-back. A read-only debug port
//                reads the same memory independently of the pipeline.
//  Ports       : clk, rst            - clock, async active-high reset
//                inEnable            - 1 advance, 0 stall (hold, no store)
//                inWB                - {RegWrite, MemtoReg}
//                inMemRead/Write     - load / store request
//                inMemSize           - 00 byte, 01 half, 1x word
//                inMemUnsigned       - zero-extend loads when 1
//                inALUResult         - byte address, also forwarded
//                inStoreData         - right-aligned store data
//                inRegF_wreg         - destination register
//                inDbgAddr           - debug word address
//                outWB, outALUResult, outRegF_wreg, outMisaligned - MEM/WB
//                outRegF_wd          - extended load data
//                outDbgData          - debug read data, 1-cycle latency
//  Revision    : 1.0  initial release
// ============================================================================
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inEnable,
    input  logic [1:0]            inWB,
    input  logic                  inMemRead,
    input  logic                  inMemWrite,
    input  logic [1:0]            inMemSize,
    input  logic                  inMemUnsigned,
    input  logic [31:0]           inALUResult,
    input  logic [31:0]           inStoreData,
    input  logic [4:0]            inRegF_wreg,
    input  logic [ADDR_WIDTH-1:0] inDbgAddr,
    output logic [1:0]            outWB,
    output logic [31:0]           outRegF_wd,
    output logic [31:0]           outALUResult,
    output logic [4:0]            outRegF_wreg,
    output logic                  outMisaligned,
    output logic [31:0]           outDbgData
);

    // ------------------------------------------------------------------
    // Address decode and alignment
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            byte_off;
    logic                  is_access;
    logic                  misaligned;
    logic                  store_en;
    logic [3:0]            store_be;
    logic [31:0]           store_data;

    // Address bits above the memory depth are dropped so accesses wrap.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^inALUResult[31:ADDR_WIDTH+2];

    assign word_addr  = inALUResult[ADDR_WIDTH+1:2];
    assign byte_off   = inALUResult[1:0];
    assign is_access  = inMemRead | inMemWrite;
    assign misaligned = is_access & misaligned_access(inMemSize, byte_off);
    assign store_en   = inEnable & inMemWrite & ~misaligned;
    assign store_be   = byte_enable(inMemSize, byte_off);
    assign store_data = store_lanes(inMemSize, inStoreData);

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0] ram_rdata;

    data_memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_data_memory (
        .clk     (clk),
        .rst     (rst),
        .a_en    (inEnable),
        .a_we    (store_en),
        .a_be    (store_be),
        .a_addr  (word_addr),
        .a_wdata (store_data),
        .a_rdata (ram_rdata),
        .b_addr  (inDbgAddr),
        .b_rdata (outDbgData)
    );

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    memwb_t memwb_next;
    memwb_t memwb_r;

    always_comb begin
        memwb_next      = '0;
        // A faulting access must never retire into the register file.
        memwb_next.wb   = misaligned ? {1'b0, inWB[WB_MEMTOREG]} : inWB;
        memwb_next.alu  = inALUResult;
        memwb_next.wreg = inRegF_wreg;
        memwb_next.mis  = misaligned;
        // A combined read+write acts as a store only; its load data is 0.
        memwb_next.load = inMemRead & ~inMemWrite & ~misaligned;
        memwb_next.size = inMemSize;
        memwb_next.uns  = inMemUnsigned;
        memwb_next.off  = byte_off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memwb_r <= '0;
        end else if (inEnable) begin
            memwb_r <= memwb_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: lane select and extension happen after the RAM register
    // so load data lines up with the pass-through fields.
    // ------------------------------------------------------------------
    assign outWB         = memwb_r.wb;
    assign outALUResult  = memwb_r.alu;
    assign outRegF_wreg  = memwb_r.wreg;
    assign outMisaligned = memwb_r.mis;
    assign outRegF_wd    = memwb_r.load
                         ? load_extend(ram_rdata, memwb_r.size, memwb_r.off, memwb_r.uns)
                         : 32'd0;

endmodule : memory_access_stage
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_stage
//  Description : Self-checking bench for memory_access_stage. A byte-array
//                reference model predicts each transaction; expectations go
//                into queues and a monitor compares them against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_access_stage;

    localparam int AW     = 6;
    localparam int NBYTES = 4 * (2 ** AW);

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] wd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inEnable = 1'b0;
    logic [1:0]    inWB = 2'b00;
    logic          inMemRead = 1'b0;
    logic          inMemWrite = 1'b0;
    logic [1:0]    inMemSize = 2'b00;
    logic          inMemUnsigned = 1'b0;
    logic [31:0]   inALUResult = 32'd0;
    logic [31:0]   inStoreData = 32'd0;
    logic [4:0]    inRegF_wreg = 5'd0;
    logic [AW-1:0] inDbgAddr = '0;
    logic [1:0]    outWB;
    logic [31:0]   outRegF_wd;
    logic [31:0]   outALUResult;
    logic [4:0]    outRegF_wreg;
    logic          outMisaligned;
    logic [31:0]   outDbgData;

    memory_access_stage #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
        .clk           (clk),
        .rst           (rst),
        .inEnable      (inEnable),
        .inWB          (inWB),
        .inMemRead     (inMemRead),
        .inMemWrite    (inMemWrite),
        .inMemSize     (inMemSize),
        .inMemUnsigned (inMemUnsigned),
        .inALUResult   (inALUResult),
        .inStoreData   (inStoreData),
        .inRegF_wreg   (inRegF_wreg),
        .inDbgAddr     (inDbgAddr),
        .outWB         (outWB),
        .outRegF_wd    (outRegF_wd),
        .outALUResult  (outALUResult),
        .outRegF_wreg  (outRegF_wreg),
        .outMisaligned (outMisaligned),
        .outDbgData    (outDbgData)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain byte-addressed memory
    // ------------------------------------------------------------------
    logic [7:0]  bmem [0:NBYTES-1];
    exp_t        exp_q[$];
    logic [31:0] dbg_q[$];

    function automatic logic [31:0] model_word(input int widx);
        int b;
        b = (widx * 4) % NBYTES;
        return {bmem[b+3], bmem[b+2], bmem[b+1], bmem[b]};
    endfunction

    // Issue one cycle of stimulus (call right after a falling edge).
    task automatic drive(input logic en, input logic re, input logic we,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [1:0] wb, input logic [4:0] wreg,
                         input logic [AW-1:0] dbg);
        exp_t e;
        int   base;
        int   nbytes;
        logic mis;
        logic [31:0] v;
        inEnable = en; inMemRead = re; inMemWrite = we; inMemSize = sz;
        inMemUnsigned = uns; inALUResult = addr; inStoreData = sdata;
        inWB = wb; inRegF_wreg = wreg; inDbgAddr = dbg;

        // Debug sees memory as it stands before this edge's store.
        dbg_q.push_back(model_word(int'(dbg)));

        base   = int'(addr % NBYTES);
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis    = (re || we) && (base % nbytes != 0);
        if (en) begin
            v = 32'd0;
            if (re && !we && !mis) begin
                if (nbytes == 1)
                    v = uns ? {24'd0, bmem[base]} : {{24{bmem[base][7]}}, bmem[base]};
                else if (nbytes == 2)
                    v = uns ? {16'd0, bmem[base+1], bmem[base]}
                            : {{16{bmem[base+1][7]}}, bmem[base+1], bmem[base]};
                else
                    v = {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
            end
            e.wb   = mis ? {1'b0, wb[0]} : wb;
            e.wd   = v;
            e.alu  = addr;
            e.wreg = wreg;
            e.mis  = mis;
            exp_q.push_back(e);
            if (we && !mis) begin
                for (int i = 0; i < nbytes; i++) bmem[base+i] = sdata[i*8 +: 8];
            end
        end
    endtask

    task automatic idle(input logic [AW-1:0] dbg);
        drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 2'b00, 5'd0, dbg);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per advancing edge; on stalls the
    // previous expectation must still be on the outputs.
    // ------------------------------------------------------------------
    exp_t        last_e = '0;
    exp_t        mon_e;
    logic [31:0] mon_d;
    logic        mon_fire;
    logic        mon_live;

    always @(posedge clk) begin
        mon_fire = inEnable;
        mon_live = !rst;
        #1;
        if (!mon_live) begin
            last_e = '0;
        end else begin
            if (mon_fire) begin
                if (exp_q.size() == 0) begin
                    check("exp_queue_empty", 32'd1, 32'd0);
                end else begin
                    last_e = exp_q.pop_front();
                end
            end
            mon_e = last_e;
            check("outWB",         {30'd0, outWB},        {30'd0, mon_e.wb});
            check("outRegF_wd",    outRegF_wd,            mon_e.wd);
            check("outALUResult",  outALUResult,          mon_e.alu);
            check("outRegF_wreg",  {27'd0, outRegF_wreg}, {27'd0, mon_e.wreg});
            check("outMisaligned", {31'd0, outMisaligned},{31'd0, mon_e.mis});
            if (dbg_q.size() == 0) begin
                check("dbg_queue_empty", 32'd1, 32'd0);
            end else begin
                mon_d = dbg_q.pop_front();
                check("outDbgData", outDbgData, mon_d);
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_outWB"},         {30'd0, outWB},         32'd0);
        check({tag, "_outALUResult"},  outALUResult,           32'd0);
        check({tag, "_outRegF_wreg"},  {27'd0, outRegF_wreg},  32'd0);
        check({tag, "_outMisaligned"}, {31'd0, outMisaligned}, 32'd0);
        check({tag, "_outRegF_wd"},    outRegF_wd,             32'd0);
        check({tag, "_outDbgData"},    outDbgData,             32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          op;

        #3;
        check_cleared("reset");

        // Give every word a known value so the model is exact.
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 2 ** AW; w++) begin
            drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), $urandom, 2'b00, 5'd0, AW'(w));
            @(negedge clk);
        end

        // Word store then load-back, then byte/half loads of the same word
        drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0, 6'd4); @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 2'b11, 5'd5, 6'd4); @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2'b11, 5'd6, 6'd4); @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2'b11, 5'd7, 6'd4); @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2'b11, 5'd8, 6'd4); @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2'b11, 5'd9, 6'd4); @(negedge clk);

        // Byte and half stores into a cleared word
        drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 2'b00, 5'd0, 6'd4); @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345678, 2'b00, 5'd0, 6'd4); @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 2'b11, 5'd1, 6'd4); @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA5555, 2'b00, 5'd0, 6'd4); @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 2'b11, 5'd2, 6'd4); @(negedge clk);

        // Misaligned word store: suppressed, flagged, RegWrite dropped
        drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h12, 32'hCAFEF00D, 2'b11, 5'd3, 6'd4); @(negedge clk);
        idle(6'd4); @(negedge clk);
        idle(6'd4); @(negedge clk);

        // Stalled store held three cycles, then released once
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h1, 2'b10, 5'd4, 6'd8); @(negedge clk);
        end
        drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h1, 2'b10, 5'd4, 6'd8); @(negedge clk);
        idle(6'd8); @(negedge clk);
        idle(6'd8); @(negedge clk);

        // Read and write together: store only, load data 0
        drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h24, 32'h0BADC0DE, 2'b11, 5'd11, 6'd9); @(negedge clk);
        idle(6'd9); @(negedge clk);

        // Randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                inEnable = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0;
                #2 rst = 1'b1;
                #1 check_cleared("midreset");
                @(negedge clk);
                rst = 1'b0;
            end
            op = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            drive($urandom_range(0, 4) != 0,
                  (op >= 2 && op <= 5) || op == 9,
                  (op >= 6),
                  sz, 1'($urandom), a, $urandom,
                  2'($urandom), 5'($urandom), AW'($urandom));
            @(negedge clk);
        end
        idle(6'd0);
        @(negedge clk);

        check("leftover_expectations", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_memory_access_stage
`default_nettype wire
